// File: rtl/clock_divider_bank_if.sv
// Control/status bundle for clock_divider_bank: per-channel enables, global sync,
// the configuration write handshake and the divided/tick outputs.
interface clock_divider_bank_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0] enable;
  logic                sync;
  logic                cfg_valid;
  logic [CW-1:0]       cfg_channel;
  logic [WIDTH-1:0]    cfg_period;
  logic [WIDTH-1:0]    cfg_high;
  logic                cfg_ready;
  logic [CHANNELS-1:0] divided;
  logic [CHANNELS-1:0] tick;

  modport master (
    output enable, sync, cfg_valid, cfg_channel, cfg_period, cfg_high,
    input  cfg_ready, divided, tick
  );

  modport slave (
    input  enable, sync, cfg_valid, cfg_channel, cfg_period, cfg_high,
    output cfg_ready, divided, tick
  );
endinterface

// File: rtl/clock_divider_bank.sv
// Bank of programmable clock dividers. Each lane runs a period counter with
// registered divided/tick outputs; config writes shadow until a period boundary.
module clock_divider_lane #(
  parameter int WIDTH          = 16,
  parameter int DEFAULT_PERIOD = 2,
  parameter int DEFAULT_HIGH   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable_i,
  input  logic             sync_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wr_period_i,
  input  logic [WIDTH-1:0] wr_high_i,
  output logic             pending_o,
  output logic             divided_o,
  output logic             tick_o
);
  logic             run_q, run_d, pend_q, pend_d, div_q, div_d, tick_q, tick_d;
  logic [WIDTH-1:0] count_q, count_d, per_q, per_d, high_q, high_d;
  logic [WIDTH-1:0] sh_per_q, sh_per_d, sh_high_q, sh_high_d;
  logic             at_end, apply;

  // Last count of a period; a programmed period of 0 behaves as 1.
  function automatic logic [WIDTH-1:0] last_cnt(input logic [WIDTH-1:0] p);
    return (p == '0) ? '0 : p - WIDTH'(1);
  endfunction

  assign at_end = count_q >= last_cnt(per_q);
  assign apply  = pend_q && (!run_q || at_end || sync_i);

  always_comb begin
    run_d     = run_q;
    count_d   = count_q;
    per_d     = per_q;
    high_d    = high_q;
    sh_per_d  = sh_per_q;
    sh_high_d = sh_high_q;
    pend_d    = pend_q;
    if (apply) begin
      per_d  = sh_per_q;
      high_d = sh_high_q;
      pend_d = 1'b0;
    end
    // Writes are only accepted while nothing is pending, so never collide with apply.
    if (wr_i) begin
      sh_per_d  = wr_period_i;
      sh_high_d = wr_high_i;
      pend_d    = 1'b1;
    end
    if (!enable_i) begin
      run_d   = 1'b0;
      count_d = '0;
    end else if (!run_q) begin
      run_d   = 1'b1;
      count_d = '0;
    end else if (apply || sync_i || at_end) begin
      count_d = '0;
    end else begin
      count_d = count_q + WIDTH'(1);
    end
    div_d  = run_d && (count_d < high_d);
    tick_d = run_d && (count_d == last_cnt(per_d));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q     <= 1'b0;
      count_q   <= '0;
      per_q     <= WIDTH'(DEFAULT_PERIOD);
      high_q    <= WIDTH'(DEFAULT_HIGH);
      sh_per_q  <= WIDTH'(DEFAULT_PERIOD);
      sh_high_q <= WIDTH'(DEFAULT_HIGH);
      pend_q    <= 1'b0;
      div_q     <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      run_q     <= run_d;
      count_q   <= count_d;
      per_q     <= per_d;
      high_q    <= high_d;
      sh_per_q  <= sh_per_d;
      sh_high_q <= sh_high_d;
      pend_q    <= pend_d;
      div_q     <= div_d;
      tick_q    <= tick_d;
    end
  end

  assign pending_o = pend_q;
  assign divided_o = div_q;
  assign tick_o    = tick_q;
endmodule

module clock_divider_bank #(
  parameter int CHANNELS       = 4,
  parameter int WIDTH          = 16,
  parameter int DEFAULT_PERIOD = 2,
  parameter int DEFAULT_HIGH   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  clock_divider_bank_if.slave  bus
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0] pending;
  logic [CHANNELS-1:0] wr;

  // Out-of-range channel numbers match no lane: ready stays high, write is dropped.
  always_comb begin
    bus.cfg_ready = 1'b1;
    for (int c = 0; c < CHANNELS; c++)
      if (bus.cfg_channel == CW'(c)) bus.cfg_ready = !pending[c];
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    assign wr[c] = bus.cfg_valid && !pending[c] && (bus.cfg_channel == CW'(c));

    clock_divider_lane #(
      .WIDTH(WIDTH), .DEFAULT_PERIOD(DEFAULT_PERIOD), .DEFAULT_HIGH(DEFAULT_HIGH)
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .enable_i   (bus.enable[c]),
      .sync_i     (bus.sync),
      .wr_i       (wr[c]),
      .wr_period_i(bus.cfg_period),
      .wr_high_i  (bus.cfg_high),
      .pending_o  (pending[c]),
      .divided_o  (bus.divided[c]),
      .tick_o     (bus.tick[c])
    );
  end
endmodule

// File: tb/tb_clock_divider_bank.sv
// Directed bench for clock_divider_bank: default pattern, idle/running reconfig,
// boundary periods, sync realignment and async reset with a write pending.
module tb_clock_divider_bank;
  localparam int CHANNELS = 4;
  localparam int WIDTH    = 16;

  logic clk = 1'b0;
  logic reset;
  int   errs = 0;
  int   checks = 0;

  clock_divider_bank_if #(.CHANNELS(CHANNELS), .WIDTH(WIDTH)) bus ();

  clock_divider_bank #(
    .CHANNELS(CHANNELS), .WIDTH(WIDTH), .DEFAULT_PERIOD(2), .DEFAULT_HIGH(1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One write; checks ready before the accepting edge and the pending state after.
  task automatic cfg_write(input int ch, input int p, input int h);
    bus.cfg_valid   = 1'b1;
    bus.cfg_channel = 2'(ch);
    bus.cfg_period  = WIDTH'(p);
    bus.cfg_high    = WIDTH'(h);
    chk($sformatf("ready before wr ch%0d", ch), 32'(bus.cfg_ready), 1);
    step();
    bus.cfg_valid = 1'b0;
    chk($sformatf("ready after wr ch%0d", ch), 32'(bus.cfg_ready), 0);
  endtask

  task automatic cfg_idle(input int ch, input int p, input int h);
    cfg_write(ch, p, h);
    step();
    chk($sformatf("ready after apply ch%0d", ch), 32'(bus.cfg_ready), 1);
  endtask

  initial begin
    reset           = 1'b1;
    bus.enable      = '0;
    bus.sync        = 1'b0;
    bus.cfg_valid   = 1'b0;
    bus.cfg_channel = '0;
    bus.cfg_period  = '0;
    bus.cfg_high    = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst divided", 32'(bus.divided), 0);
    chk("rst tick", 32'(bus.tick), 0);
    chk("rst ready", 32'(bus.cfg_ready), 1);
    reset = 1'b0;

    // Defaults 2/1 on ch0
    bus.enable = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("def div0 c%0d", i), 32'(bus.divided[0]), 32'(i % 2 == 0));
      chk($sformatf("def tick0 c%0d", i), 32'(bus.tick[0]), 32'(i % 2 == 1));
    end

    // Idle write ch1 5/2, then run ch0 and ch1 together
    bus.enable = '0;
    step();
    chk("disable div", 32'(bus.divided), 0);
    chk("disable tick", 32'(bus.tick), 0);
    cfg_idle(1, 5, 2);
    bus.enable = 4'b0011;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("n5 div1 c%0d", i), 32'(bus.divided[1]), 32'((i % 5) < 2));
      chk($sformatf("n5 tick1 c%0d", i), 32'(bus.tick[1]), 32'((i % 5) == 4));
      chk($sformatf("n5 div0 c%0d", i), 32'(bus.divided[0]), 32'(i % 2 == 0));
      chk($sformatf("n5 tick0 c%0d", i), 32'(bus.tick[0]), 32'(i % 2 == 1));
    end

    // Ch0 running 4/2, rewrite to 6/3 at count 1
    bus.enable = '0;
    step();
    cfg_idle(0, 4, 2);
    bus.enable = 4'b0001;
    step();
    chk("n4 c0 div", 32'(bus.divided[0]), 1);
    step();
    chk("n4 c1 div", 32'(bus.divided[0]), 1);
    chk("n4 c1 tick", 32'(bus.tick[0]), 0);
    cfg_write(0, 6, 3);
    chk("n4 c2 div", 32'(bus.divided[0]), 0);
    chk("n4 c2 tick", 32'(bus.tick[0]), 0);
    step();
    chk("n4 c3 div", 32'(bus.divided[0]), 0);
    chk("n4 c3 tick", 32'(bus.tick[0]), 1);
    chk("n4 c3 ready", 32'(bus.cfg_ready), 0);
    step();
    chk("n6 c0 div", 32'(bus.divided[0]), 1);
    chk("n6 c0 tick", 32'(bus.tick[0]), 0);
    chk("n6 c0 ready", 32'(bus.cfg_ready), 1);
    for (int i = 1; i < 12; i++) begin
      step();
      chk($sformatf("n6 div0 c%0d", i), 32'(bus.divided[0]), 32'((i % 6) < 3));
      chk($sformatf("n6 tick0 c%0d", i), 32'(bus.tick[0]), 32'((i % 6) == 5));
    end

    // Boundaries: ch2 N=0 H=0, ch3 N=3 H=7
    bus.enable = '0;
    step();
    cfg_idle(2, 0, 0);
    cfg_idle(3, 3, 7);
    bus.enable = 4'b1100;
    for (int i = 0; i < 7; i++) begin
      step();
      chk($sformatf("n0 div2 c%0d", i), 32'(bus.divided[2]), 0);
      chk($sformatf("n0 tick2 c%0d", i), 32'(bus.tick[2]), 1);
      chk($sformatf("h7 div3 c%0d", i), 32'(bus.divided[3]), 1);
      chk($sformatf("h7 tick3 c%0d", i), 32'(bus.tick[3]), 32'((i % 3) == 2));
    end

    // Sync: ch0 4/2, ch1 6/3
    bus.enable = '0;
    step();
    cfg_idle(0, 4, 2);
    cfg_idle(1, 6, 3);
    bus.enable = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("pre sync div0 c%0d", i), 32'(bus.divided[0]), 32'(i < 2));
      chk($sformatf("pre sync div1 c%0d", i), 32'(bus.divided[1]), 1);
    end
    bus.sync = 1'b1;
    step();
    bus.sync = 1'b0;
    chk("sync div", 32'(bus.divided[1:0]), 32'b11);
    chk("sync tick", 32'(bus.tick[1:0]), 0);
    step();
    step();
    chk("sync c2 div0", 32'(bus.divided[0]), 0);
    step();
    chk("sync c3 tick0", 32'(bus.tick[0]), 1);
    chk("sync c3 div1", 32'(bus.divided[1]), 0);
    bus.sync = 1'b1;
    step();
    bus.sync = 1'b0;
    chk("wrapsync div", 32'(bus.divided[1:0]), 32'b11);
    chk("wrapsync tick0", 32'(bus.tick[0]), 0);
    step();
    chk("wrapsync c1 div0", 32'(bus.divided[0]), 1);
    step();
    chk("wrapsync c2 tick0", 32'(bus.tick[0]), 0);
    step();
    chk("wrapsync c3 tick0", 32'(bus.tick[0]), 1);

    // Async reset with a pending write on running ch1
    cfg_write(1, 9, 9);
    #2;
    reset = 1'b1;
    #1;
    chk("arst divided", 32'(bus.divided), 0);
    chk("arst tick", 32'(bus.tick), 0);
    chk("arst ready", 32'(bus.cfg_ready), 1);
    bus.enable = 4'b0010;
    #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("arst div1 c%0d", i), 32'(bus.divided[1]), 32'(i % 2 == 0));
      chk($sformatf("arst tick1 c%0d", i), 32'(bus.tick[1]), 32'(i % 2 == 1));
      chk($sformatf("arst div0 c%0d", i), 32'(bus.divided[0]), 0);
    end
    chk("arst ready end", 32'(bus.cfg_ready), 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/clock_divider_bank.md
# clock_divider_bank

Multi-channel programmable clock-enable/divider generator: each of `CHANNELS` channels produces a registered divided waveform with runtime-programmable period and high time, plus a one-cycle end-of-period tick. It supersedes the fixed single-divisor divider in the LED front end, feeding shift-clock, latch and PWM-frame timing. Configuration changes are deferred to period boundaries so outputs never emit runt pulses. A global `sync` realigns all channels in phase.

## Interface
- `CHANNELS`, 4: number of independent channels (≥1).
- `WIDTH`, 16: counter, period and high-time width in bits.
- `DEFAULT_PERIOD`, 2: period loaded into every channel at reset.
- `DEFAULT_HIGH`, 1: high time loaded into every channel at reset.
- `CW` (localparam): `max(1, $clog2(CHANNELS))`.

- `clk` in 1: sole clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in CHANNELS: per-channel run request, sampled each edge.
- `sync` in 1: one-cycle pulse; restart all channels at count 0.
- `cfg_valid` in 1: configuration write request.
- `cfg_channel` in CW: target channel of the write.
- `cfg_period` in WIDTH: new period N in cycles; 0 is treated as 1.
- `cfg_high` in WIDTH: new high time H in cycles.
- `cfg_ready` out 1: write accepted on an edge where `cfg_valid && cfg_ready`.
- `divided` out CHANNELS: registered divided waveform.
- `tick` out CHANNELS: registered one-cycle end-of-period strobe.

## Operation
- Per channel c, state: `run`, `count[WIDTH]`, active `period`/`high`, shadow `period`/`high`, `pending`.
- Neff = max(period, 1).
- Counter, per edge, in priority order:
  - `enable[c]` = 0: `run` ← 0, `count` ← 0.
  - `run` = 0 and `enable[c]` = 1: `run` ← 1, `count` stays 0, so the first running cycle has count 0.
  - `run` = 1 and `sync`: `count` ← 0.
  - `run` = 1 and `count` ≥ Neff−1: `count` ← 0 (wrap).
  - Otherwise: `count` ← `count` + 1.
- Outputs in any cycle, as flops carrying the value for the current state:
  - `divided[c]` = `run && count < high`. H = 0 gives constant low; H ≥ Neff gives constant high while running.
  - `tick[c]` = `run && count == Neff−1`. With Neff = 1, tick is high every running cycle.
- Configuration:
  - `cfg_ready` = `!pending[cfg_channel]`. A `cfg_channel` ≥ CHANNELS gives `cfg_ready` = 1; the write is accepted and discarded.
  - An accepted write loads the shadow registers and sets `pending`.
  - The shadow is applied (active ← shadow, `pending` ← 0) at the first later edge where any of these holds: `run` = 0, a wrap occurs, or `sync` is asserted.
  - The application edge also sets `count` ← 0, so the new settings start from count 0 in the next cycle.
- Simultaneous events:
  - `sync` on a wrap edge: a single restart.
  - `enable` dropping on the same edge as `sync` or a wrap: the channel stops.
  - A write to channel c on the same edge as c's apply condition sets `pending`; it is applied at the next qualifying edge, not the current one.

## Timing
- Reset (asynchronous):
  - `count` = 0, `run` = 0, `pending` = 0.
  - active and shadow registers = DEFAULT_PERIOD / DEFAULT_HIGH.
  - `divided` = 0, `tick` = 0, `cfg_ready` = 1.
- Reset asserted mid-period or mid-update: the pending write is lost and defaults are restored immediately.
- Enable to first output: `enable` sampled 1 at edge e puts count 0 in the following cycle, with `divided` = (H > 0) in that cycle.
- Disable: `enable` sampled 0 at edge e forces `divided` = 0 and `tick` = 0 from the following cycle.
- Config latency, running channel: the new settings take effect in the cycle after the first wrap edge following acceptance. Worst case is Neff_old + 1 cycles.
- Config latency, idle channel: 2 edges after acceptance.
- `cfg_ready` for channel c falls in the cycle after acceptance and rises in the cycle after the apply edge.
- Arithmetic is unsigned WIDTH-bit throughout. `count` never exceeds Neff−1 because the period changes only at count 0.

## Test plan
- Reset, then `enable`=1 with defaults 2/1 → `divided` 1,0,1,0…; `tick` 0,1,0,1…
- Write ch1 N=5, H=2 while idle, then enable → `divided` 1,1,0,0,0 repeating; `tick` high only at count 4; ch0 unaffected.
- Ch0 running N=4, H=2; write N=6, H=3 at count 1 → `cfg_ready` low; old waveform finishes counts 2,3; new 6-cycle waveform starts after the wrap; `cfg_ready` returns high.
- Boundary values:
  - N=0, H=0 → `divided` constant 0, `tick` constant 1.
  - N=3, H=7 → `divided` constant 1, `tick` every 3rd cycle.
- Ch0 N=4 and ch1 N=6 running; pulse `sync` → both channels show count 0 in the next cycle (`divided` high, H≥1); `sync` on a ch0 wrap edge gives a single restart.
- Async `reset` mid-period with a write pending → all outputs 0 immediately; defaults restored; `cfg_ready` = 1; enable → 1,0 pattern.
